// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - CP0 register file and commit-stage exception/interrupt/eret sequencer
module cp0_exc_unit #(
    parameter logic [31:0] EXC_VECTOR      = 32'h0000_1000,
    parameter int          IRQ_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        exc_ri,
    input  logic        exc_sys,
    input  logic        exc_ov,
    input  logic        exc_ret,
    input  logic        cowrite,
    input  logic [4:0]  co_waddr,
    input  logic [31:0] co_wdata,
    input  logic [4:0]  co_raddr,
    output logic [31:0] co_rdata,
    input  logic        irq,
    output logic        user_mode,
    output logic        exc_flush,
    output logic [31:0] exc_pc
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    typedef enum logic {S_IDLE, S_FLUSH} state_e;

    state_e                     state_q, state_d;
    logic [31:0]                count_q, count_d, compare_q, compare_d;
    logic [31:0]                epc_q, epc_d, exc_pc_q, exc_pc_d;
    logic                       ie_q, ie_d, exl_q, exl_d, um_q, um_d;
    logic                       timer_q, timer_d;
    logic [1:0]                 ip_sw_q, ip_sw_d;
    logic [4:0]                 exccode_q, exccode_d;
    logic [IRQ_SYNC_STAGES-1:0] irq_sync_q;

    logic        irq_s, int_pending, take_exc, do_eret, do_write;
    logic [4:0]  exc_code;
    logic [31:0] cause_val;

    assign irq_s       = irq_sync_q[IRQ_SYNC_STAGES-1];
    assign cause_val   = {16'd0, timer_q, 4'd0, irq_s, ip_sw_q, 1'b0, exccode_q, 2'b00};
    assign int_pending = ie_q & ~exl_q & (|cause_val[15:8]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // One event per cycle, decided by fixed priority; a losing cowrite is dropped.
    always_comb begin
        take_exc = 1'b0;
        exc_code = 5'd0;
        do_eret  = 1'b0;
        do_write = 1'b0;
        state_d  = S_IDLE;
        if (state_q == S_IDLE && commit_valid) begin
            if (exc_ri)           begin take_exc = 1'b1; exc_code = 5'd10; end
            else if (exc_sys)     begin take_exc = 1'b1; exc_code = 5'd8;  end
            else if (exc_ov)      begin take_exc = 1'b1; exc_code = 5'd12; end
            else if (int_pending) begin take_exc = 1'b1; exc_code = 5'd0;  end
            else if (exc_ret)     do_eret  = 1'b1;
            else if (cowrite)     do_write = 1'b1;
            if (take_exc || do_eret) state_d = S_FLUSH;
        end
    end

    always_comb begin
        exc_flush = (state_q == S_FLUSH);
        exc_pc    = exc_pc_q;
        user_mode = um_q & ~exl_q;
    end

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        timer_d   = timer_q | (count_q == compare_q);
        ie_d      = ie_q;
        exl_d     = exl_q;
        um_d      = um_q;
        ip_sw_d   = ip_sw_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        exc_pc_d  = exc_pc_q;
        if (do_write) begin
            case (co_waddr)
                REG_COUNT:   count_d = co_wdata;
                REG_COMPARE: begin compare_d = co_wdata; timer_d = 1'b0; end
                REG_STATUS:  begin ie_d = co_wdata[0]; exl_d = co_wdata[1]; um_d = co_wdata[4]; end
                REG_CAUSE:   ip_sw_d = co_wdata[9:8];
                REG_EPC:     epc_d = co_wdata;
                default: ;
            endcase
        end
        if (take_exc) begin
            epc_d     = commit_pc;
            exccode_d = exc_code;
            exl_d     = 1'b1;
            exc_pc_d  = EXC_VECTOR;
        end
        if (do_eret) begin
            exl_d    = 1'b0;
            exc_pc_d = epc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= 32'd0;
            compare_q  <= 32'hFFFF_FFFF;
            epc_q      <= 32'd0;
            exc_pc_q   <= 32'd0;
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            um_q       <= 1'b0;
            timer_q    <= 1'b0;
            ip_sw_q    <= 2'd0;
            exccode_q  <= 5'd0;
            irq_sync_q <= '0;
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            exc_pc_q   <= exc_pc_d;
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            um_q       <= um_d;
            timer_q    <= timer_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            irq_sync_q <= {irq_sync_q[IRQ_SYNC_STAGES-2:0], irq};
        end
    end

    always_comb begin
        co_rdata = 32'd0;
        case (co_raddr)
            REG_COUNT:   co_rdata = count_q;
            REG_COMPARE: co_rdata = compare_q;
            REG_STATUS:  co_rdata = {27'd0, um_q, 2'b00, exl_q, ie_q};
            REG_CAUSE:   co_rdata = cause_val;
            REG_EPC:     co_rdata = epc_q;
            default:     co_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - directed self-checking bench for cp0_exc_unit
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        exc_ri, exc_sys, exc_ov, exc_ret, cowrite;
    logic [4:0]  co_waddr, co_raddr;
    logic [31:0] co_wdata, co_rdata;
    logic        irq, user_mode, exc_flush;
    logic [31:0] exc_pc;

    int checks = 0;
    int errors = 0;

    cp0_exc_unit #(.EXC_VECTOR(32'h0000_1000), .IRQ_SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .exc_ri(exc_ri), .exc_sys(exc_sys), .exc_ov(exc_ov), .exc_ret(exc_ret),
        .cowrite(cowrite), .co_waddr(co_waddr), .co_wdata(co_wdata),
        .co_raddr(co_raddr), .co_rdata(co_rdata), .irq(irq),
        .user_mode(user_mode), .exc_flush(exc_flush), .exc_pc(exc_pc)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        commit_valid = 1'b0; commit_pc = 32'd0;
        exc_ri = 1'b0; exc_sys = 1'b0; exc_ov = 1'b0; exc_ret = 1'b0;
        cowrite = 1'b0; co_waddr = 5'd0; co_wdata = 32'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        co_raddr = a;
        #1;
        check(tag, co_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        commit_valid = 1'b1; cowrite = 1'b1; co_waddr = a; co_wdata = d;
        cyc();
        idle_in();
    endtask

    initial begin
        idle_in();
        irq = 1'b0; co_raddr = 5'd0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_flush", {31'd0, exc_flush}, 32'd0);
        check("rst_um", {31'd0, user_mode}, 32'd0);
        check("rst_excpc", exc_pc, 32'd0);
        check_reg("rst_compare", 5'd11, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("idle_flush", {31'd0, exc_flush}, 32'd0);
        end
        check_reg("count5", 5'd9, 32'd5);
        check_reg("status0", 5'd12, 32'd0);

        // syscall from user mode
        mtc0(5'd12, 32'h11);
        check("um_set", {31'd0, user_mode}, 32'd1);
        check_reg("status11", 5'd12, 32'h11);
        commit_valid = 1'b1; exc_sys = 1'b1; commit_pc = 32'h400;
        cyc();
        commit_pc = 32'h500;
        check("sys_flush", {31'd0, exc_flush}, 32'd1);
        check("sys_pc", exc_pc, 32'h1000);
        check("sys_um", {31'd0, user_mode}, 32'd0);
        check_reg("sys_epc", 5'd14, 32'h400);
        check_reg("sys_cause", 5'd13, 32'h20);
        cyc();
        idle_in();
        check("flush_1cyc", {31'd0, exc_flush}, 32'd0);
        check_reg("flush_ignored", 5'd14, 32'h400);

        // eret, with a syscall presented in its flush cycle
        commit_valid = 1'b1; exc_ret = 1'b1;
        cyc();
        exc_ret = 1'b0; exc_sys = 1'b1; commit_pc = 32'h600;
        check("eret_flush", {31'd0, exc_flush}, 32'd1);
        check("eret_pc", exc_pc, 32'h400);
        check("eret_um", {31'd0, user_mode}, 32'd1);
        check_reg("eret_status", 5'd12, 32'h11);
        cyc();
        idle_in();
        check_reg("eret_epc_kept", 5'd14, 32'h400);
        check("eret_noflush", {31'd0, exc_flush}, 32'd0);

        // priority: ri beats ov and the cowrite
        commit_valid = 1'b1; exc_ri = 1'b1; exc_ov = 1'b1; cowrite = 1'b1;
        co_waddr = 5'd14; co_wdata = 32'hDEAD; commit_pc = 32'h80;
        cyc();
        idle_in();
        check("ri_flush", {31'd0, exc_flush}, 32'd1);
        check_reg("ri_cause", 5'd13, 32'h28);
        check_reg("ri_epc", 5'd14, 32'h80);
        cyc();

        mtc0(5'd13, 32'hFFFF_FFFF);
        check_reg("cause_wr", 5'd13, 32'h328);
        mtc0(5'd13, 32'h0);
        check_reg("cause_clr", 5'd13, 32'h28);
        mtc0(5'd5, 32'h1234);
        check_reg("unmapped", 5'd5, 32'd0);

        // timer interrupt
        mtc0(5'd12, 32'h01);
        check_reg("status01", 5'd12, 32'h01);
        mtc0(5'd9, 32'd15);
        check_reg("count_wr", 5'd9, 32'd15);
        mtc0(5'd11, 32'd20);
        repeat (4) cyc();
        check_reg("count20", 5'd9, 32'd20);
        check_reg("timer_pre", 5'd13, 32'h28);
        cyc();
        check_reg("timer_set", 5'd13, 32'h8028);
        check("int_needs_commit", {31'd0, exc_flush}, 32'd0);
        commit_valid = 1'b1; commit_pc = 32'h200;
        cyc();
        idle_in();
        check("int_flush", {31'd0, exc_flush}, 32'd1);
        check("int_pc", exc_pc, 32'h1000);
        check_reg("int_cause", 5'd13, 32'h8000);
        check_reg("int_epc", 5'd14, 32'h200);
        cyc();
        mtc0(5'd11, 32'd100);
        check_reg("timer_clr", 5'd13, 32'h0);
        check_reg("compare100", 5'd11, 32'd100);

        // irq, then reset in the flush cycle
        commit_valid = 1'b1; exc_ret = 1'b1;
        cyc();
        idle_in();
        check("eret2_pc", exc_pc, 32'h200);
        cyc();
        irq = 1'b1;
        cyc();
        cyc();
        check_reg("irq_sync", 5'd13, 32'h400);
        irq = 1'b0; commit_valid = 1'b1; commit_pc = 32'h300;
        cyc();
        idle_in();
        check("irq_flush", {31'd0, exc_flush}, 32'd1);
        check("irq_pc", exc_pc, 32'h1000);
        reset = 1'b1;
        #1;
        check("mid_rst_flush", {31'd0, exc_flush}, 32'd0);
        check("mid_rst_pc", exc_pc, 32'd0);
        check("mid_rst_um", {31'd0, user_mode}, 32'd0);
        check_reg("mid_rst_status", 5'd12, 32'd0);
        check_reg("mid_rst_cause", 5'd13, 32'd0);
        check_reg("mid_rst_epc", 5'd14, 32'd0);
        check_reg("mid_rst_compare", 5'd11, 32'hFFFF_FFFF);
        check_reg("mid_rst_count", 5'd9, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc();
        check("post_rst_flush", {31'd0, exc_flush}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
